// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the CPU data-memory controller.
package cpu_mem_pkg;

  localparam logic [14:0] RAM_TOP  = 15'h5FFF;
  localparam logic [14:0] SW_ADDR  = 15'h6000;
  localparam logic [14:0] LED_ADDR = 15'h6001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2
  } mem_state_t;

  // True when the address falls inside the RAM window.
  function automatic logic is_ram_addr(input logic [14:0] addr);
    return (addr <= RAM_TOP);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, cleared on reset.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Resample the async input twice so metastability settles before use.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_ctrl.sv
// CPU data-memory controller: one-word read hold register in front of a
// synchronous RAM with configurable read latency, plus SW/LED MMIO.
module mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [14:0] data_addr,
  input  logic        read_m,
  input  logic        write_m,
  input  logic [15:0] out_m,
  output logic [15:0] in_m,
  output logic        stall,
  input  logic [3:0]  SW,
  output logic [15:0] led,
  output logic [14:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [15:0] ram_rdata
);

  // Counter starts at RD_LAT-1; WAIT runs RD_LAT-1 cycles so FILL lands
  // exactly on the cycle the RAM presents the data.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  mem_state_t  state_q;
  logic        hold_valid_q;
  logic [14:0] hold_tag_q;
  logic [15:0] hold_data_q;
  logic [1:0]  cnt_q;
  logic [14:0] req_addr_q;
  logic [15:0] led_q;
  logic [3:0]  sw_sync_s;

  logic        is_ram_s;
  logic        hit_s;
  logic        stall_s;
  logic        wr_ok_s;

  sync2 #(.WIDTH(4)) u_sw_sync (
    .clk_i  (clk),
    .rst_ni (resetN),
    .d_i    (SW),
    .q_o    (sw_sync_s)
  );

  assign is_ram_s = is_ram_addr(data_addr);
  assign hit_s    = read_m && is_ram_s && hold_valid_q && (hold_tag_q == data_addr);
  assign stall_s  = read_m && is_ram_s && !hit_s;
  assign stall    = stall_s;

  // A miss issues its read only from IDLE; writes are accepted only in IDLE
  // and never alongside a read, so the RAM port is never double-booked.
  assign ram_re    = resetN && (state_q == IDLE) && stall_s;
  assign wr_ok_s   = resetN && write_m && (state_q == IDLE) && !stall_s;
  assign ram_we    = wr_ok_s && is_ram_s;
  assign ram_addr  = (state_q == IDLE) ? data_addr : req_addr_q;
  assign ram_wdata = out_m;
  assign led       = led_q;

  // Read-data mux: hold register, MMIO, or zero (including while stalled).
  always_comb begin
    in_m = 16'h0000;
    if (hit_s) begin
      in_m = hold_data_q;
    end else if (read_m && (data_addr == SW_ADDR)) begin
      in_m = {12'h000, sw_sync_s};
    end else if (read_m && (data_addr == LED_ADDR)) begin
      in_m = led_q;
    end else begin
      in_m = 16'h0000;
    end
  end

  // Miss FSM, hold register, write-through coherence and LED register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_tag_q   <= 15'h0000;
      hold_data_q  <= 16'h0000;
      cnt_q        <= 2'd0;
      req_addr_q   <= 15'h0000;
      led_q        <= 16'h0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (stall_s) begin
            req_addr_q <= data_addr;
            cnt_q      <= CNT_INIT;
            state_q    <= (RD_LAT == 1) ? FILL : WAIT;
          end else if (wr_ok_s) begin
            if (is_ram_s && hold_valid_q && (hold_tag_q == data_addr)) begin
              hold_data_q <= out_m;
            end
            if (data_addr == LED_ADDR) begin
              led_q <= out_m;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_q <= FILL;
          end
        end
        FILL: begin
          hold_data_q  <= ram_rdata;
          hold_tag_q   <= req_addr_q;
          hold_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench: instance 0 uses RD_LAT=1, instance 1 uses RD_LAT=3.
module tb_mem_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic [14:0] addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [15:0] wdat  [2];
  logic [3:0]  sw    [2];
  logic [15:0] in_o  [2];
  logic        stall_o [2];
  logic [15:0] led_o [2];
  logic [14:0] raddr_o [2];
  logic [15:0] rwdata_o [2];
  logic        we_o  [2];
  logic        re_o  [2];
  logic [15:0] rdata [2];

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q [$];

  mem_ctrl #(.RD_LAT(1)) dut0 (
    .clk(clk), .resetN(rst_n[0]), .data_addr(addr[0]), .read_m(rd[0]),
    .write_m(wr[0]), .out_m(wdat[0]), .in_m(in_o[0]), .stall(stall_o[0]),
    .SW(sw[0]), .led(led_o[0]), .ram_addr(raddr_o[0]), .ram_wdata(rwdata_o[0]),
    .ram_we(we_o[0]), .ram_re(re_o[0]), .ram_rdata(rdata[0]));

  mem_ctrl #(.RD_LAT(3)) dut1 (
    .clk(clk), .resetN(rst_n[1]), .data_addr(addr[1]), .read_m(rd[1]),
    .write_m(wr[1]), .out_m(wdat[1]), .in_m(in_o[1]), .stall(stall_o[1]),
    .SW(sw[1]), .led(led_o[1]), .ram_addr(raddr_o[1]), .ram_wdata(rwdata_o[1]),
    .ram_we(we_o[1]), .ram_re(re_o[1]), .ram_rdata(rdata[1]));

  // RAM models: data is only valid exactly RD_LAT cycles after ram_re,
  // otherwise a poison value shows up so early/late capture is caught.
  logic [15:0] mem0 [0:24575];
  logic [15:0] mem1 [0:24575];
  logic        v0;
  logic [15:0] d0;
  logic        v1 [3];
  logic [15:0] d1 [3];

  function automatic logic [15:0] ram_init(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5C3;
  endfunction

  always @(posedge clk) begin
    if (we_o[0]) mem0[raddr_o[0]] <= rwdata_o[0];
    v0 <= re_o[0];
    if (re_o[0]) d0 <= mem0[raddr_o[0]];
    if (we_o[1]) mem1[raddr_o[1]] <= rwdata_o[1];
    v1[0] <= re_o[1];
    if (re_o[1]) d1[0] <= mem1[raddr_o[1]];
    v1[1] <= v1[0]; d1[1] <= d1[0];
    v1[2] <= v1[1]; d1[2] <= d1[1];
  end
  assign rdata[0] = v0 ? d0 : 16'hDEAD;
  assign rdata[1] = v1[2] ? d1[2] : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue a read, count stalled cycles and ram_re pulses, then compare data.
  task automatic read_check(input int sel, input logic [14:0] a, input logic [15:0] exp,
                            input int exp_stall, input string name);
    int n;
    int res;
    logic [14:0] re_addr;
    logic [15:0] e;
    @(negedge clk);
    rd[sel] = 1'b1; wr[sel] = 1'b0; addr[sel] = a;
    exp_q.push_back(exp);
    #1;
    n = 0; res = 0; re_addr = 15'h0000;
    while (stall_o[sel] && n < 40) begin
      if (re_o[sel]) begin res++; re_addr = raddr_o[sel]; end
      check({name, "_in_stalled"}, {16'h0000, in_o[sel]}, 32'h0);
      @(negedge clk); #1;
      n++;
    end
    check({name, "_stall_cycles"}, n, exp_stall);
    if (exp_stall > 0) begin
      check({name, "_re_pulses"}, res, 1);
      check({name, "_re_addr"}, {17'h0, re_addr}, {17'h0, a});
    end else begin
      check({name, "_no_re"}, {31'h0, re_o[sel]}, 32'h0);
    end
    e = exp_q.pop_front();
    check({name, "_data"}, {16'h0000, in_o[sel]}, {16'h0000, e});
  endtask

  // One-cycle write, optionally with a simultaneous read (hit expected).
  task automatic write_op(input int sel, input logic [14:0] a, input logic [15:0] d,
                          input logic rd_too, input logic [15:0] exp_in, input string name);
    logic [15:0] led_before;
    logic [15:0] e;
    @(negedge clk);
    addr[sel] = a; wr[sel] = 1'b1; wdat[sel] = d; rd[sel] = rd_too;
    led_before = led_o[sel];
    if (rd_too) exp_q.push_back(exp_in);
    #1;
    check({name, "_we"}, {31'h0, we_o[sel]}, {31'h0, (a <= 15'h5FFF)});
    check({name, "_re_off"}, {31'h0, re_o[sel]}, 32'h0);
    if (a <= 15'h5FFF) begin
      check({name, "_waddr"}, {17'h0, raddr_o[sel]}, {17'h0, a});
      check({name, "_wdata"}, {16'h0, rwdata_o[sel]}, {16'h0, d});
    end
    if (rd_too) begin
      e = exp_q.pop_front();
      check({name, "_stall"}, {31'h0, stall_o[sel]}, 32'h0);
      check({name, "_old_data"}, {16'h0, in_o[sel]}, {16'h0, e});
    end
    @(negedge clk);
    wr[sel] = 1'b0; rd[sel] = 1'b0;
    #1;
    check({name, "_led"}, {16'h0, led_o[sel]}, {16'h0, (a == 15'h6001) ? d : led_before});
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
    int          stall;
    string       name;
  } vec_t;

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < 24576; i++) begin
      mem0[i] = ram_init(15'(i));
      mem1[i] = ram_init(15'(i));
    end
    mem0[16'h0010] = 16'hBEEF;
    v0 = 1'b0; d0 = 16'h0000;
    for (int i = 0; i < 3; i++) begin v1[i] = 1'b0; d1[i] = 16'h0000; end
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; addr[s] = 15'h0000; rd[s] = 1'b0; wr[s] = 1'b0; wdat[s] = 16'h0000;
    end
    sw[0] = 4'b1010;
    sw[1] = 4'b0101;

    // Reset state, including MMIO read of the still-cleared synchroniser.
    repeat (3) @(negedge clk);
    rd[0] = 1'b1; addr[0] = 15'h6000;
    #1;
    check("rst_led", {16'h0, led_o[0]}, 32'h0);
    check("rst_stall", {31'h0, stall_o[0]}, 32'h0);
    check("rst_re", {31'h0, re_o[0]}, 32'h0);
    check("rst_we", {31'h0, we_o[0]}, 32'h0);
    check("rst_sw_in", {16'h0, in_o[0]}, 32'h0);
    @(negedge clk);
    rd[0] = 1'b0; rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    tbl.push_back('{1'b0, 1'b1, 15'h0010, 16'h0000, 16'hBEEF, 2, "miss_0010"});
    tbl.push_back('{1'b0, 1'b1, 15'h0010, 16'h0000, 16'hBEEF, 0, "hit_0010"});
    tbl.push_back('{1'b1, 1'b1, 15'h0010, 16'hBEF0, 16'hBEEF, 0, "rmw_0010"});
    tbl.push_back('{1'b0, 1'b1, 15'h0010, 16'h0000, 16'hBEF0, 0, "hit_new_0010"});
    tbl.push_back('{1'b1, 1'b0, 15'h6001, 16'h00A5, 16'h0000, 0, "wr_led"});
    tbl.push_back('{1'b0, 1'b1, 15'h6001, 16'h0000, 16'h00A5, 0, "rd_led"});
    tbl.push_back('{1'b0, 1'b1, 15'h7000, 16'h0000, 16'h0000, 0, "rd_unmapped"});
    tbl.push_back('{1'b1, 1'b0, 15'h7000, 16'h1234, 16'h0000, 0, "wr_unmapped"});
    tbl.push_back('{1'b0, 1'b1, 15'h6001, 16'h0000, 16'h00A5, 0, "rd_led_again"});
    tbl.push_back('{1'b0, 1'b1, 15'h0011, 16'h0000, ram_init(15'h0011), 2, "miss_0011"});
    tbl.push_back('{1'b0, 1'b1, 15'h0010, 16'h0000, 16'hBEF0, 2, "remiss_0010"});
    tbl.push_back('{1'b0, 1'b1, 15'h5FFF, 16'h0000, ram_init(15'h5FFF), 2, "miss_top"});
    tbl.push_back('{1'b0, 1'b1, 15'h6000, 16'h0000, {12'h000, sw[0]}, 0, "rd_sw"});
    tbl.push_back('{1'b1, 1'b0, 15'h5FFF, 16'h7777, 16'h0000, 0, "wt_top"});
    tbl.push_back('{1'b0, 1'b1, 15'h5FFF, 16'h0000, 16'h7777, 0, "hit_top"});
    tbl.push_back('{1'b1, 1'b0, 15'h0020, 16'h4242, 16'h0000, 0, "wr_0020"});
    tbl.push_back('{1'b0, 1'b1, 15'h0020, 16'h0000, 16'h4242, 2, "miss_0020"});

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) write_op(0, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].exp, tbl[i].name);
      else           read_check(0, tbl[i].addr, tbl[i].exp, tbl[i].stall, tbl[i].name);
    end

    // RD_LAT=3: four stalled cycles, single ram_re, then a hit and MMIO.
    read_check(1, 15'h0020, ram_init(15'h0020), 4, "l3_miss_0020");
    read_check(1, 15'h0020, ram_init(15'h0020), 0, "l3_hit_0020");
    write_op(1, 15'h6001, 16'h0055, 1'b0, 16'h0000, "l3_wr_led");
    read_check(1, 15'h6000, {12'h000, sw[1]}, 0, "l3_rd_sw");

    // Reset asserted while the FSM is in WAIT.
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = 15'h0030;
    #1;
    check("wrst_re_issue", {31'h0, re_o[1]}, 32'h1);
    @(negedge clk); #1;
    check("wrst_in_wait_re", {31'h0, re_o[1]}, 32'h0);
    rst_n[1] = 1'b0;
    #1;
    check("wrst_led", {16'h0, led_o[1]}, 32'h0);
    check("wrst_re", {31'h0, re_o[1]}, 32'h0);
    check("wrst_we", {31'h0, we_o[1]}, 32'h0);
    check("wrst_stall", {31'h0, stall_o[1]}, 32'h1);
    check("wrst_in", {16'h0, in_o[1]}, 32'h0);
    repeat (2) @(negedge clk);
    rd[1] = 1'b0; rst_n[1] = 1'b1;
    read_check(1, 15'h0030, ram_init(15'h0030), 4, "wrst_remiss_0030");
    read_check(1, 15'h0020, ram_init(15'h0020), 4, "wrst_remiss_0020");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter RD_LAT, default 1, RAM read latency in cycles from ram_re to valid ram_rdata; legal range 1..4.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 resetN  in  1  reset, asynchronous assert, active-low.
REQ-004 data_addr  in  15  CPU data address.
REQ-005 read_m  in  1  CPU read request, combinational, held stable while stall=1.
REQ-006 write_m  in  1  CPU write strobe, already gated by !stall.
REQ-007 out_m  in  16  CPU write data.
REQ-008 in_m  out  16  read data to CPU, combinational.
REQ-009 stall  out  1  freezes the CPU while read data is unavailable.
REQ-010 SW  in  4  asynchronous board switches.
REQ-011 led  out  16  LED register.
REQ-012 ram_addr / ram_wdata / ram_we / ram_re  out  15/16/1/1  synchronous RAM port.
REQ-013 ram_rdata  in  16  RAM read data, valid RD_LAT cycles after ram_re.

Function
REQ-014 Address map: 0x0000-0x5FFF RAM; 0x6000 SW (zero-extended, read-only); 0x6001 LED (read/write); 0x6002-0x7FFF reads 0, writes dropped.
REQ-015 One-word hold register: hold_valid, hold_tag[14:0], hold_data[15:0].
REQ-016 hit = read_m && RAM address && hold_valid && hold_tag==data_addr.
REQ-017 stall = read_m && RAM address && !hit, combinational; MMIO and unmapped reads never stall.
REQ-018 in_m = hold_data on hit; sync SW on 0x6000; led on 0x6001; 16'h0000 otherwise, including while stall=1.
REQ-019 FSM states IDLE, WAIT, FILL; reset state IDLE.
REQ-020 IDLE: stall=1 -> ram_re=1 for one cycle, ram_addr=data_addr, latch req_addr, load counter with RD_LAT-1, go WAIT.
REQ-021 WAIT: decrement counter; counter==0 -> go FILL; ram_re=0.
REQ-022 FILL: capture ram_rdata into hold_data, set hold_tag=req_addr and hold_valid=1, go IDLE.
REQ-023 Miss latency: stall high for exactly RD_LAT+1 cycles; data is never bypassed from ram_rdata.
REQ-024 data_addr changes during WAIT/FILL are ignored; a tag mismatch after FILL causes a new miss.
REQ-025 Write to RAM: ram_we=1, ram_addr=data_addr, ram_wdata=out_m in the same cycle; zero-latency posted write.
REQ-026 Write to hold_tag address while hold_valid: hold_data updated to out_m (write-through coherence).
REQ-027 Read and write to the same address in one cycle (e.g. M=M+1) on a hit: in_m returns the old value; hold and RAM take the new value at the edge.
REQ-028 ram_re and ram_we are never asserted in the same cycle; write_m is ignored unless the state is IDLE.
REQ-029 Write to 0x6001 loads led from out_m at the clock edge.
REQ-030 SW passes through a 2-flop synchroniser before use.

Reset
REQ-031 resetN=0 asynchronously forces: state IDLE, hold_valid=0, hold_tag=0, hold_data=0, counter=0, led=0, synchroniser=0.
REQ-032 Outputs during reset: ram_re=0, ram_we=0, stall=0 unless read_m targets RAM; in-flight RAM data is discarded.

Structure
REQ-033 Package cpu_mem_pkg holds the constants RAM_TOP=0x5FFF, SW_ADDR=0x6000, LED_ADDR=0x6001 and the typedef mem_state_t {IDLE, WAIT, FILL}.
REQ-034 Sub-module sync2 (parameterised width, 2-flop synchroniser, async active-low reset) is instantiated for SW.

Verification
REQ-035 RD_LAT=1, read 0x0010 (RAM=0xBEEF) after reset -> stall high 2 cycles, then in_m=0xBEEF, stall=0.
REQ-036 RD_LAT=3, read 0x0020 -> stall high 4 cycles, ram_re pulses exactly once with ram_addr=0x0020.
REQ-037 Hit 0x0010 with write_m=1, out_m=0xBEF0 -> in_m=0xBEEF that cycle; next read of 0x0010 -> no stall, in_m=0xBEF0, RAM holds 0xBEF0.
REQ-038 Write 0x6001=0x00A5 -> led=0x00A5 next cycle; SW=4'b1010 held 3 cycles, read 0x6000 -> in_m=0x000A, stall=0.
REQ-039 resetN pulsed low in WAIT -> state IDLE, hold_valid=0, led=0; re-read of the same address misses again.
REQ-040 Read 0x7000 -> in_m=0, stall=0; write 0x7000 -> ram_we=0, led unchanged.
